// File: rtl/risc_pkg.sv
// Shared definitions for the RISC execute datapath: function encodings,
// default widths and the shift-stage occupancy encoding.
package risc_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int TAGW_DEF  = 5;
   localparam int SHAMT_W   = 5;

   typedef enum logic [1:0] {
      FUNC_SLL  = 2'b00,
      FUNC_SRL  = 2'b01,
      FUNC_PASS = 2'b10,
      FUNC_RSVD = 2'b11
   } func_t;

   // Bit 1 is S1 (operand) valid, bit 0 is S2 (result) valid.
   typedef enum logic [1:0] {
      OCC_EMPTY  = 2'b00,
      OCC_S2ONLY = 2'b01,
      OCC_S1ONLY = 2'b10,
      OCC_FULL   = 2'b11
   } occ_t;

endpackage

// File: rtl/shift_decode.sv
// Maps the held function and shift amount onto the Shifter direction controls
// and flags shift amounts that fall outside the datapath width.
module shift_decode
   import risc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic                     vld,
   input  logic [1:0]               func,
   input  logic [WIDTH-1:SHAMT_W]   d2_hi,
   output logic                     sli,
   output logic                     sri,
   output logic                     ovf
);

   logic big;

   assign big = |d2_hi;

   // PASS and the reserved code leave the Shifter transparent and never overflow.
   always_comb begin
      sli = 1'b0;
      sri = 1'b0;
      ovf = 1'b0;
      if (vld) begin
         case (func)
            FUNC_SLL: begin
               sli = 1'b1;
               ovf = big;
            end
            FUNC_SRL: begin
               sri = 1'b1;
               ovf = big;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/shift_stage.sv
// Two-entry shift execute stage: latches operands, drives the shared external
// Shifter, captures its result and hands it to writeback over valid/ready.
module shift_stage
   import risc_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int TAGW  = TAGW_DEF
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             InValid,
   output logic             InReady,
   input  logic [1:0]       Func,
   input  logic [WIDTH-1:0] InD1,
   input  logic [WIDTH-1:0] InD2,
   input  logic [TAGW-1:0]  InRd,
   output logic [WIDTH-1:0] ShD1,
   output logic [WIDTH-1:0] ShD2,
   output logic             ShSLI,
   output logic             ShSRI,
   input  logic [WIDTH-1:0] ShDOut,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] OutData,
   output logic [TAGW-1:0]  OutRd,
   output logic             OutZero,
   output logic             OutOvf
);

   occ_t             occ;
   logic             vld_p1, vld_p2;
   logic             s2_free, accept, move, drain;
   logic             nxt_v1, nxt_v2;
   logic [1:0]       func_p1;
   logic [WIDTH-1:0] d1_p1, d2_p1;
   logic [TAGW-1:0]  rd_p1;
   logic             sli, sri, ovf;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] data_p2;
   logic [TAGW-1:0]  rd_p2;
   logic             zero_p2, ovf_p2;

   // An out-of-range shift amount forces the result to zero.
   function automatic logic [WIDTH-1:0] sat_ovf(input logic o, input logic [WIDTH-1:0] x);
      return o ? '0 : x;
   endfunction

   assign vld_p1  = occ[1];
   assign vld_p2  = occ[0];
   assign s2_free = !vld_p2 || OutReady;
   assign InReady = !vld_p1 || s2_free;
   assign accept  = InValid && InReady;
   assign move    = vld_p1 && s2_free;
   assign drain   = vld_p2 && OutReady;
   assign nxt_v1  = accept || (vld_p1 && !move);
   assign nxt_v2  = move || (vld_p2 && !drain);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) occ <= OCC_EMPTY;
      else     occ <= occ_t'({nxt_v1, nxt_v2});
   end

   // ---- p1: operand register feeding the Shifter ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         func_p1 <= FUNC_PASS;
         d1_p1   <= '0;
         d2_p1   <= '0;
         rd_p1   <= '0;
      end else if (accept) begin
         func_p1 <= Func;
         d1_p1   <= InD1;
         d2_p1   <= InD2;
         rd_p1   <= InRd;
      end
   end

   shift_decode #(.WIDTH(WIDTH)) u_decode (
      .vld   (vld_p1),
      .func  (func_p1),
      .d2_hi (d2_p1[WIDTH-1:SHAMT_W]),
      .sli   (sli),
      .sri   (sri),
      .ovf   (ovf)
   );

   assign ShD1  = d1_p1;
   assign ShD2  = d2_p1;
   assign ShSLI = sli;
   assign ShSRI = sri;
   assign res   = sat_ovf(ovf, ShDOut);

   // ---- p2: result register presented to writeback ----
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         data_p2 <= '0;
         rd_p2   <= '0;
         zero_p2 <= 1'b1;
         ovf_p2  <= 1'b0;
      end else if (move) begin
         data_p2 <= res;
         rd_p2   <= rd_p1;
         zero_p2 <= (res == '0);
         ovf_p2  <= ovf;
      end
   end

   assign OutValid = vld_p2;
   assign OutData  = data_p2;
   assign OutRd    = rd_p2;
   assign OutZero  = zero_p2;
   assign OutOvf   = ovf_p2;

endmodule
